// File: rtl/alu_op_sequencer.sv
// Drives registered operands/mode into a combinational ALU, samples c_in after SETTLE_CYCLES,
// and queues {result, mode} in a small FIFO. Define ALU_SEQ_CHECK_EN to build the result checker.
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_mode,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] mode_out,
  input  logic [WIDTH-1:0] c_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] rsp_mode,
  output logic             rsp_err,
  output logic             busy,
  output logic             check_fail
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] settle_reg;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] fifo_count;
  logic             fifo_full, accept, push, pop;

  logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] mode_mem [FIFO_DEPTH];

  assign fifo_full = (fifo_count == OCC_W'(FIFO_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state_reg == DRIVE) && (settle_reg == '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   if (settle_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready = !fifo_full;
      DRIVE:   busy = 1'b1;
      default: ;
    endcase
  end

  // Operands change only on accept so the ALU inputs stay stable between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_reg <= '0;
      a_out      <= '0;
      b_out      <= '0;
      mode_out   <= '0;
    end else if (accept) begin
      settle_reg <= CNT_W'(SETTLE_CYCLES - 1);
      a_out      <= cmd_a;
      b_out      <= cmd_b;
      mode_out   <= cmd_mode;
    end else if (state_reg == DRIVE && settle_reg != '0) begin
      settle_reg <= settle_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + OCC_W'(1);
        2'b01:   fifo_count <= fifo_count - OCC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= c_in;
      mode_mem[wr_ptr] <= mode_out;
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = data_mem[rd_ptr];
  assign rsp_mode  = mode_mem[rd_ptr];

`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] expected;
  logic             err;
  logic             err_mem [FIFO_DEPTH];
  logic             check_fail_reg;

  always_comb begin
    expected = '0;
    case (mode_out)
      WIDTH'(0): expected = a_out + b_out;
      WIDTH'(1): expected = a_out - b_out;
      WIDTH'(2): expected = b_out - a_out;
      WIDTH'(3): expected = a_out * b_out;
      WIDTH'(4): expected = a_out >> b_out;
      WIDTH'(5): expected = a_out << b_out;
      WIDTH'(6): expected = b_out >> a_out;
      WIDTH'(7): expected = b_out << a_out;
      default:   expected = WIDTH'(42);
    endcase
  end

  assign err = (c_in != expected);

  always_ff @(posedge clk) begin
    if (push) err_mem[wr_ptr] <= err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            check_fail_reg <= 1'b0;
    else if (push && err)  check_fail_reg <= 1'b1;
  end

  assign rsp_err    = err_mem[rd_ptr];
  assign check_fail = check_fail_reg;
`else
  assign rsp_err    = 1'b0;
  assign check_fail = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a behavioural ALU drives c_in, and a queue-based
// model predicts handshakes, response order/content, and reset behaviour.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
  localparam int DEPTH  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0, cmd_mode = '0;
  logic [WIDTH-1:0] a_out, b_out, mode_out, c_in;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data, rsp_mode;
  logic             rsp_err, busy, check_fail;
  logic [WIDTH-1:0] corrupt = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode),
    .a_out(a_out), .b_out(b_out), .mode_out(mode_out), .c_in(c_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_mode(rsp_mode), .rsp_err(rsp_err),
    .busy(busy), .check_fail(check_fail)
  );

  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    int unsigned ai, bi, r;
    ai = a;
    bi = b;
    case (m)
      8'd0:    r = ai + bi;
      8'd1:    r = ai - bi;
      8'd2:    r = bi - ai;
      8'd3:    r = ai * bi;
      8'd4:    r = ai >> bi;
      8'd5:    r = ai << bi;
      8'd6:    r = bi >> ai;
      8'd7:    r = bi << ai;
      default: r = 42;
    endcase
    return r[WIDTH-1:0];
  endfunction

  // Behavioural ALU; 'corrupt' lets the bench inject wrong results.
  assign c_in = alu_ref(a_out, b_out, mode_out) ^ corrupt;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] mode;
    logic             err;
  } rsp_t;

  rsp_t             exp_q[$];
  bit               pending = 0;
  int               edge_n = 0;
  int               done_edge = 0;
  logic [WIDTH-1:0] a_lat = '0, b_lat = '0, m_lat = '0;
  bit               fail_sticky = 0;
  int               n_acc = 0;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, advance the model across the edge.
  task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] m, input bit rdy, input logic [WIDTH-1:0] cor);
    bit   exp_ready, acc, pp;
    rsp_t r;
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_mode  = m;
    rsp_ready = rdy;
    exp_ready = !pending && (exp_q.size() < DEPTH);
    check_eq("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    check_eq("busy", 32'(busy), 32'(pending));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
      check_eq("rsp_mode", 32'(rsp_mode), 32'(exp_q[0].mode));
      check_eq("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
    end
    acc = v && exp_ready;
    pp  = rdy && (exp_q.size() != 0);
    if (v && cmd_ready) n_acc++;
    if (acc) corrupt = cor;
    @(posedge clk);
    edge_n++;
    if (pp) void'(exp_q.pop_front());
    if (pending && edge_n == done_edge) begin
      r.data = alu_ref(a_lat, b_lat, m_lat) ^ corrupt;
      r.mode = m_lat;
`ifdef ALU_SEQ_CHECK_EN
      r.err = (corrupt != '0);
`else
      r.err = 1'b0;
`endif
      if (r.err) fail_sticky = 1;
      exp_q.push_back(r);
      pending = 0;
    end
    if (acc) begin
      a_lat     = a;
      b_lat     = b;
      m_lat     = m;
      pending   = 1;
      done_edge = edge_n + SETTLE;
    end
    #1;
    check_eq("a_out", 32'(a_out), 32'(a_lat));
    check_eq("b_out", 32'(b_out), 32'(b_lat));
    check_eq("mode_out", 32'(mode_out), 32'(m_lat));
    check_eq("check_fail", 32'(check_fail), 32'(fail_sticky));
    $display("[TB] cyc=%0d v=%0b acc=%0b pop=%0b q=%0d a=%h b=%h m=%h", edge_n, v, acc, pp,
             exp_q.size(), a, b, m);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_a_out"}, 32'(a_out), 32'h0);
    check_eq({tag, "_b_out"}, 32'(b_out), 32'h0);
    check_eq({tag, "_mode_out"}, 32'(mode_out), 32'h0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_check_fail"}, 32'(check_fail), 32'h0);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
  endtask

  logic [WIDTH-1:0] dir_a [4] = '{8'd3, 8'd3, 8'd16, 8'd7};
  logic [WIDTH-1:0] dir_b [4] = '{8'd5, 8'd5, 8'd16, 8'd1};
  logic [WIDTH-1:0] dir_m [4] = '{8'd0, 8'd1, 8'd3, 8'd9};

  initial begin
    #2;
    check_reset_values("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed: add, sub, truncated product, unknown mode.
    for (int i = 0; i < 4; i++) begin
      step(1, dir_a[i], dir_b[i], dir_m[i], 1, '0);
      for (int k = 0; k < SETTLE; k++) step(0, '0, '0, '0, 1, '0);
    end
    for (int k = 0; k < 3; k++) step(0, '0, '0, '0, 1, '0);

    // Fill the FIFO with the consumer stalled, then push and pop on the same edge.
    n_acc = 0;
    for (int i = 0; i < 6 * (SETTLE + 1); i++)
      step(1, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom_range(0, 9)), 0, '0);
    check_eq("accepted_when_full", 32'(n_acc), 32'(DEPTH));
    step(0, '0, '0, '0, 1, '0);
    step(1, 8'd9, 8'd4, 8'd2, 0, '0);
    for (int k = 0; k < SETTLE - 1; k++) step(0, '0, '0, '0, 0, '0);
    step(0, '0, '0, '0, 1, '0);
    for (int k = 0; k < DEPTH + 2; k++) step(0, '0, '0, '0, 1, '0);

    // Random traffic with occasional corrupted ALU results.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] m, cor;
      m   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 9));
      cor = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(1, 255)) : '0;
      step(($urandom_range(0, 9) < 6), WIDTH'($urandom), WIDTH'($urandom), m,
           ($urandom_range(0, 1) == 1), cor);
    end
    for (int k = 0; k < DEPTH + SETTLE + 2; k++) step(0, '0, '0, '0, 1, '0);

    // Reset in DRIVE with two results queued.
    for (int j = 0; j < 2; j++) begin
      step(1, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom_range(0, 7)), 0, '0);
      for (int k = 0; k < SETTLE; k++) step(0, '0, '0, '0, 0, '0);
    end
    step(1, 8'hAA, 8'h55, 8'd0, 0, '0);
    check_eq("pre_reset_queued", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    pending     = 0;
    a_lat       = '0;
    b_lat       = '0;
    m_lat       = '0;
    fail_sticky = 0;
    corrupt     = '0;
    for (int k = 0; k < SETTLE + 3; k++) step(0, '0, '0, '0, 1, '0);
    step(1, 8'd3, 8'd5, 8'd0, 1, '0);
    for (int k = 0; k < SETTLE + 2; k++) step(0, '0, '0, '0, 1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
